// File: rtl/enemy_fire_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_fire_scheduler_if
//  Description : Shot request handshake between the enemy fire scheduler
//                (master) and the enemy-bullet launcher (slave).
//                  fire_req          master->slave  request, IDs valid while high
//                  ID_enemy_tiro_X   master->slave  flattened shooter index
//                  ID_enemy_tiro_Y   master->slave  shooter row
//                  fire_ack          slave->master  launcher accepted the shot
//  Revision    : 1.0  initial release
// ============================================================================
interface enemy_fire_scheduler_if;
  logic       fire_req;
  logic       fire_ack;
  logic [5:0] ID_enemy_tiro_X;
  logic [5:0] ID_enemy_tiro_Y;

  modport master (
    output fire_req,
    output ID_enemy_tiro_X,
    output ID_enemy_tiro_Y,
    input  fire_ack
  );

  modport slave (
    input  fire_req,
    input  ID_enemy_tiro_X,
    input  ID_enemy_tiro_Y,
    output fire_ack
  );
endinterface
`default_nettype wire

// File: rtl/enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_fire_scheduler
//  Description : Decides when the invader formation fires and which enemy
//                fires. After a cooldown, and once no enemy bullet is in
//                flight, a pseudo-random start column is picked and columns
//                are scanned round-robin for the bottom-most live enemy, whose
//                indices are offered to the launcher through a req/ack
//                handshake.
//  Ports       : clk          system clock
//                reset        asynchronous active-low reset
//                enable       game in progress; low aborts any activity
//                vivo         enemy alive flags, index = row*COLUNAS+col
//                shot_busy    enemy bullet currently in flight
//                fire         handshake interface (master side)
//                shots_fired  count of acknowledged shots, wraps at 255
//  Revision    : 1.0  initial release
// ============================================================================
module enemy_fire_scheduler #(
  parameter int          COLUNAS  = 10,
  parameter int          LINHAS   = 4,
  parameter logic [23:0] COOLDOWN = 24'd5_000_000,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [LINHAS*COLUNAS-1:0]   vivo,
  input  logic                        shot_busy,
  enemy_fire_scheduler_if.master      fire,
  output logic [7:0]                  shots_fired
);

  localparam int                 c_cells    = LINHAS * COLUNAS;
  localparam int                 c_col_w    = (COLUNAS > 1) ? $clog2(COLUNAS) : 1;
  localparam int                 c_idx_w    = (c_cells > 1) ? $clog2(c_cells) : 1;
  localparam logic [15:0]        c_seed     = (SEED == 16'd0) ? 16'hACE1 : SEED;
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(COLUNAS - 1);
  localparam logic [7:0]         c_cols8    = 8'(COLUNAS);
  localparam logic [23:0]        c_reload   = COOLDOWN - 24'd1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COOL      = 3'd1,
    WAIT_FREE = 3'd2,
    PICK      = 3'd3,
    SCAN      = 3'd4,
    REQ       = 3'd5
  } state_t;

  state_t               r_state;
  logic [15:0]          r_lfsr;
  logic [23:0]          r_cnt;
  logic [c_col_w-1:0]   r_col;
  logic [c_col_w-1:0]   r_step;
  logic                 r_fire_req;
  logic [5:0]           r_id_x;
  logic [5:0]           r_id_y;
  logic [7:0]           r_shots;

  // Column-major view of vivo so the scan can address one column at a time.
  logic [LINHAS-1:0] w_grid [COLUNAS];

  generate
    for (genvar gc = 0; gc < COLUNAS; gc++) begin : g_col
      for (genvar gr = 0; gr < LINHAS; gr++) begin : g_row
        assign w_grid[gc][gr] = vivo[gr*COLUNAS + gc];
      end
    end
  endgenerate

  logic [LINHAS-1:0] w_col_bits;
  logic              w_hit;
  logic [5:0]        w_hit_row;
  logic [5:0]        w_hit_x;
  logic [7:0]        w_start;
  logic              w_target_alive;
  logic              w_lfsr_fb;

  assign w_col_bits     = w_grid[r_col];
  assign w_start        = r_lfsr[7:0] % c_cols8;
  assign w_target_alive = vivo[r_id_x[c_idx_w-1:0]];
  assign w_lfsr_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Later rows override earlier ones, so the bottom-most live enemy wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_row = 6'd0;
    for (int r = 0; r < LINHAS; r++) begin
      if (w_col_bits[r]) begin
        w_hit     = 1'b1;
        w_hit_row = 6'(r);
      end
    end
    w_hit_x = w_hit_row * 6'(COLUNAS) + 6'(r_col);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_lfsr     <= c_seed;
      r_cnt      <= 24'd0;
      r_col      <= '0;
      r_step     <= '0;
      r_fire_req <= 1'b0;
      r_id_x     <= 6'd0;
      r_id_y     <= 6'd0;
      r_shots    <= 8'd0;
    end else begin
      // The LFSR free-runs so the start column depends on elapsed time.
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};

      if (!enable) begin
        r_state    <= IDLE;
        r_fire_req <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt   <= c_reload;
            r_state <= COOL;
          end
          COOL: begin
            if (r_cnt == 24'd0) r_state <= WAIT_FREE;
            else                r_cnt   <= r_cnt - 24'd1;
          end
          WAIT_FREE: begin
            if (!shot_busy) r_state <= PICK;
          end
          PICK: begin
            r_col   <= c_col_w'(w_start);
            r_step  <= '0;
            r_state <= SCAN;
          end
          SCAN: begin
            if (w_hit) begin
              r_id_x     <= w_hit_x;
              r_id_y     <= w_hit_row;
              r_fire_req <= 1'b1;
              r_state    <= REQ;
            end else if (r_step == c_last_col) begin
              // Every column was empty: the formation is gone.
              r_state <= IDLE;
            end else begin
              r_col  <= (r_col == c_last_col) ? '0 : r_col + 1'b1;
              r_step <= r_step + 1'b1;
            end
          end
          REQ: begin
            // Ack has priority over a simultaneous death of the shooter.
            if (fire.fire_ack) begin
              r_fire_req <= 1'b0;
              r_shots    <= r_shots + 8'd1;
              r_cnt      <= c_reload;
              r_state    <= COOL;
            end else if (!w_target_alive) begin
              r_fire_req <= 1'b0;
              r_state    <= PICK;
            end
          end
          default: begin
            r_fire_req <= 1'b0;
            r_state    <= IDLE;
          end
        endcase
      end
    end
  end

  assign fire.fire_req        = r_fire_req;
  assign fire.ID_enemy_tiro_X = r_id_x;
  assign fire.ID_enemy_tiro_Y = r_id_y;
  assign shots_fired          = r_shots;

endmodule
`default_nettype wire

// File: tb/tb_enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enemy_fire_scheduler
//  Description : Self-checking bench for enemy_fire_scheduler with a small
//                expected-shooter scoreboard and a reference LFSR model used
//                to predict the start column when every enemy is alive.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_enemy_fire_scheduler;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        enable    = 1'b0;
  logic        shot_busy = 1'b0;
  logic [39:0] vivo      = 40'd0;
  logic [7:0]  shots_fired;

  enemy_fire_scheduler_if fire_bus ();

  enemy_fire_scheduler #(
    .COLUNAS  (10),
    .LINHAS   (4),
    .COOLDOWN (24'd8),
    .SEED     (16'hACE1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .vivo        (vivo),
    .shot_busy   (shot_busy),
    .fire        (fire_bus),
    .shots_fired (shots_fired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
  } exp_t;

  exp_t sb[$];

  // Reference Fibonacci LFSR, taps 16,14,13,11, with two cycles of history.
  logic [15:0] m_lfsr, m_prev1, m_prev2;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr  <= 16'hACE1;
      m_prev1 <= 16'hACE1;
      m_prev2 <= 16'hACE1;
    end else begin
      m_prev2 <= m_prev1;
      m_prev1 <= m_lfsr;
      m_lfsr  <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (fire_bus.fire_req) ok = 1'b1;
    end
  endtask

  task automatic watch_quiet(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(negedge clk);
      if (fire_bus.fire_req) highs++;
    end
  endtask

  task automatic sb_compare(input string tag);
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq({tag, "_x"}, 32'(fire_bus.ID_enemy_tiro_X), 32'(e.x));
      check_eq({tag, "_y"}, 32'(fire_bus.ID_enemy_tiro_Y), 32'(e.y));
    end
  endtask

  task automatic ack_pulse();
    fire_bus.fire_ack = 1'b1;
    @(negedge clk);
    fire_bus.fire_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit         ok;
    int         highs;
    int         exp_col;
    int         first_col;
    bit         varied;
    int         got_col;

    fire_bus.fire_ack = 1'b0;
    tick(3);
    check_eq("rst_req",   32'(fire_bus.fire_req), 0);
    check_eq("rst_x",     32'(fire_bus.ID_enemy_tiro_X), 0);
    check_eq("rst_y",     32'(fire_bus.ID_enemy_tiro_Y), 0);
    check_eq("rst_shots", 32'(shots_fired), 0);
    reset = 1'b1;
    tick(2);

    // Single live enemy at index 23 (row 2, column 3).
    vivo[23] = 1'b1;
    sb.push_back('{x: 6'd23, y: 6'd2});
    enable = 1'b1;
    wait_req(22, ok);
    check_eq("t1_req_in_time", 32'(ok), 1);
    sb_compare("t1");
    ack_pulse();
    check_eq("t1_req_drop", 32'(fire_bus.fire_req), 0);
    check_eq("t1_shots",    32'(shots_fired), 1);

    // Ack outside REQ must be ignored.
    fire_bus.fire_ack = 1'b1;
    tick(2);
    fire_bus.fire_ack = 1'b0;
    check_eq("stray_ack_shots", 32'(shots_fired), 1);

    // Empty formation: no request ever, FSM keeps cycling.
    vivo = 40'd0;
    watch_quiet(80, highs);
    check_eq("empty_no_req", 32'(highs), 0);
    vivo[5] = 1'b1;
    sb.push_back('{x: 6'd5, y: 6'd0});
    wait_req(40, ok);
    check_eq("e5_req", 32'(ok), 1);
    sb_compare("e5");

    // Target dies during REQ: request withdrawn and re-targeted.
    vivo = 40'd0;
    vivo[12] = 1'b1;
    @(negedge clk);
    check_eq("kill_drop", 32'(fire_bus.fire_req), 0);
    sb.push_back('{x: 6'd12, y: 6'd1});
    wait_req(15, ok);
    check_eq("e12_req", 32'(ok), 1);
    sb_compare("e12");
    check_eq("kill_shots", 32'(shots_fired), 1);

    // Ack and death in the same cycle: ack wins.
    vivo = 40'd0;
    vivo[7] = 1'b1;
    ack_pulse();
    check_eq("ackdeath_shots", 32'(shots_fired), 2);
    check_eq("ackdeath_drop",  32'(fire_bus.fire_req), 0);
    sb.push_back('{x: 6'd7, y: 6'd0});

    // Bullet in flight parks the FSM.
    shot_busy = 1'b1;
    watch_quiet(60, highs);
    check_eq("busy_no_req", 32'(highs), 0);
    shot_busy = 1'b0;
    wait_req(13, ok);
    check_eq("busy_release_req", 32'(ok), 1);
    sb_compare("e7");

    // Enable drop during REQ.
    enable = 1'b0;
    @(negedge clk);
    check_eq("en_drop_req",   32'(fire_bus.fire_req), 0);
    check_eq("en_drop_x",     32'(fire_bus.ID_enemy_tiro_X), 7);
    check_eq("en_drop_y",     32'(fire_bus.ID_enemy_tiro_Y), 0);
    check_eq("en_drop_shots", 32'(shots_fired), 2);

    // Reset in the middle of COOL clears outputs asynchronously.
    enable = 1'b1;
    tick(3);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_req",   32'(fire_bus.fire_req), 0);
    check_eq("arst_x",     32'(fire_bus.ID_enemy_tiro_X), 0);
    check_eq("arst_y",     32'(fire_bus.ID_enemy_tiro_Y), 0);
    check_eq("arst_shots", 32'(shots_fired), 0);
    @(negedge clk);
    reset = 1'b1;

    // Full formation: bottom row fires, start column follows the LFSR
    // (value seen during PICK, two cycles before fire_req is observed).
    vivo      = {40{1'b1}};
    first_col = -1;
    varied    = 1'b0;
    for (int i = 0; i < 256; i++) begin
      wait_req(40, ok);
      check_eq("full_req", 32'(ok), 1);
      if (!ok) break;
      exp_col = int'(m_prev2[7:0]) % 10;
      check_eq("full_x", 32'(fire_bus.ID_enemy_tiro_X), 32'(30 + exp_col));
      check_eq("full_y", 32'(fire_bus.ID_enemy_tiro_Y), 3);
      got_col = int'(fire_bus.ID_enemy_tiro_X) - 30;
      if (first_col < 0) first_col = got_col;
      else if (got_col != first_col) varied = 1'b1;
      ack_pulse();
      check_eq("full_shots", 32'(shots_fired), 32'((i + 1) % 256));
      check_eq("full_drop",  32'(fire_bus.fire_req), 0);
    end
    check_eq("start_cols_vary", 32'(varied), 1);
    check_eq("shots_wrap",      32'(shots_fired), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
